// File: rtl/input_debouncer.sv
// input_debouncer: per-bit hold-time debouncer with rise/fall strobes and a merging change-event channel
module input_debouncer #(
  parameter int WIDTH = 1,
  parameter int COUNT_BITS = 16,
  parameter int HOLD_CYCLES = 50000,
  parameter logic [WIDTH-1:0] RESET_LEVEL = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             event_valid,
  input  logic             event_ready,
  output logic [WIDTH-1:0] event_state,
  output logic [WIDTH-1:0] event_mask,
  output logic             event_merged
);
  typedef enum logic {STABLE, SETTLING} state_t;
  localparam logic [COUNT_BITS:0] HOLD = (COUNT_BITS + 1)'(HOLD_CYCLES);
  localparam logic [COUNT_BITS:0] ONE = {{COUNT_BITS{1'b0}}, 1'b1};
  state_t st [WIDTH];
  logic [COUNT_BITS-1:0] cnt [WIDTH];
  logic [COUNT_BITS:0] inc [WIDTH];
  logic [WIDTH-1:0] differ, commit;
  logic acc;
  always_comb begin
    differ = in ^ out;
    commit = '0;
    acc = event_valid && event_ready;
    for (int i = 0; i < WIDTH; i++) begin
      inc[i] = {1'b0, cnt[i]} + ONE;
      commit[i] = differ[i] && ((st[i] == STABLE ? ONE : inc[i]) == HOLD);
    end
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < WIDTH; i++) begin
        st[i] <= STABLE;
        cnt[i] <= '0;
      end
      out <= RESET_LEVEL;
      rise <= '0;
      fall <= '0;
      event_valid <= 1'b0;
      event_state <= '0;
      event_mask <= '0;
      event_merged <= 1'b0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        st[i] <= (differ[i] && !commit[i]) ? SETTLING : STABLE;
        cnt[i] <= (differ[i] && !commit[i]) ? inc[i][COUNT_BITS-1:0] : '0;
      end
      out <= out ^ commit;
      rise <= commit & in;
      fall <= commit & ~in;
      // a still-unaccepted event absorbs new commits instead of dropping them
      if (|commit) begin
        event_valid <= 1'b1;
        event_state <= out ^ commit;
        event_mask <= (event_valid && !acc) ? (event_mask | commit) : commit;
        event_merged <= event_valid && !acc;
      end else if (acc) begin
        event_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_input_debouncer.sv
// tb_input_debouncer: scoreboard bench for a HOLD=4 and a HOLD=1 debouncer driven by the same inputs
module tb_input_debouncer;
  typedef struct packed {
    logic [1:0] o, r, f;
    logic       v;
    logic [1:0] s, m;
    logic       g;
  } exp_t;

  logic clock = 1'b0;
  logic reset, event_ready;
  logic [1:0] in;
  logic [1:0] out0, rise0, fall0, st0, mk0, out1, rise1, fall1, st1, mk1;
  logic v0, g0, v1, g1;

  exp_t [1:0] exp_q [$];
  exp_t [1:0] e_mon, a_mon;
  int total = 0;
  int bad = 0;

  int hold [2] = '{4, 1};
  logic [1:0] rl [2] = '{2'b10, 2'b00};
  logic [1:0] mo [2], mr [2], mf [2], ms [2], mm [2];
  logic mv [2], mg [2];
  int hist [2][2][$];

  always #5 clock = ~clock;

  input_debouncer #(.WIDTH(2), .COUNT_BITS(8), .HOLD_CYCLES(4), .RESET_LEVEL(2'b10)) dut0 (
    .clock(clock), .reset(reset), .in(in), .out(out0), .rise(rise0), .fall(fall0),
    .event_valid(v0), .event_ready(event_ready), .event_state(st0), .event_mask(mk0),
    .event_merged(g0));

  input_debouncer #(.WIDTH(2), .COUNT_BITS(4), .HOLD_CYCLES(1), .RESET_LEVEL(2'b00)) dut1 (
    .clock(clock), .reset(reset), .in(in), .out(out1), .rise(rise1), .fall(fall1),
    .event_valid(v1), .event_ready(event_ready), .event_state(st1), .event_mask(mk1),
    .event_merged(g1));

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mo[d] = rl[d];
      mr[d] = '0;
      mf[d] = '0;
      ms[d] = '0;
      mm[d] = '0;
      mv[d] = 1'b0;
      mg[d] = 1'b0;
      for (int b = 0; b < 2; b++) hist[d][b].delete();
    end
  endtask

  // a bit commits when its last HOLD samples since reset all disagree with the stable level
  task automatic model_edge();
    logic [1:0] c;
    logic acc;
    if (!reset) return;
    for (int d = 0; d < 2; d++) begin
      c = '0;
      for (int b = 0; b < 2; b++) begin
        hist[d][b].push_front(int'(in[b]));
        if (hist[d][b].size() > hold[d]) void'(hist[d][b].pop_back());
        if (hist[d][b].size() == hold[d]) begin
          c[b] = 1'b1;
          for (int k = 0; k < hist[d][b].size(); k++)
            if (hist[d][b][k] == int'(mo[d][b])) c[b] = 1'b0;
        end
      end
      acc = mv[d] && event_ready;
      mr[d] = '0;
      mf[d] = '0;
      for (int b = 0; b < 2; b++)
        if (c[b]) begin
          if (in[b]) mr[d][b] = 1'b1;
          else mf[d][b] = 1'b1;
          mo[d][b] = in[b];
        end
      if (c != 2'b00) begin
        ms[d] = mo[d];
        if (!mv[d] || acc) begin
          mm[d] = c;
          mg[d] = 1'b0;
        end else begin
          mm[d] = mm[d] | c;
          mg[d] = 1'b1;
        end
        mv[d] = 1'b1;
      end else if (acc) begin
        mv[d] = 1'b0;
      end
    end
  endtask

  task automatic push_exp();
    exp_t [1:0] e;
    for (int d = 0; d < 2; d++)
      e[d] = '{o: mo[d], r: mr[d], f: mf[d], v: mv[d], s: ms[d], m: mm[d], g: mg[d]};
    exp_q.push_back(e);
  endtask

  task automatic step(input logic [1:0] iv, input logic rv, input logic rs);
    @(posedge clock);
    model_edge();
    #1;
    in = iv;
    event_ready = rv;
    reset = rs;
    if (!rs) model_reset();
    push_exp();
  endtask

  task automatic rep(input int n, input logic [1:0] iv, input logic rv);
    for (int i = 0; i < n; i++) step(iv, rv, 1'b1);
  endtask

  always @(negedge clock) begin
    if (exp_q.size() != 0) begin
      e_mon = exp_q.pop_front();
      a_mon[0] = {out0, rise0, fall0, v0, st0, mk0, g0};
      a_mon[1] = {out1, rise1, fall1, v1, st1, mk1, g1};
      for (int d = 0; d < 2; d++) begin
        total++;
        if (a_mon[d] !== e_mon[d]) begin
          bad++;
          $display("FAIL dut%0d t=%0t out/rise/fall/valid/state/mask/merged got %b/%b/%b/%b/%b/%b/%b want %b/%b/%b/%b/%b/%b/%b",
                   d, $time, a_mon[d].o, a_mon[d].r, a_mon[d].f, a_mon[d].v, a_mon[d].s, a_mon[d].m, a_mon[d].g,
                   e_mon[d].o, e_mon[d].r, e_mon[d].f, e_mon[d].v, e_mon[d].s, e_mon[d].m, e_mon[d].g);
        end
      end
    end
  end

  initial begin
    logic [1:0] cur, iv;
    reset = 1'b1;
    in = 2'b10;
    event_ready = 1'b0;
    #1 reset = 1'b0;
    model_reset();
    step(2'b10, 1'b0, 1'b0);
    step(2'b10, 1'b0, 1'b1);
    rep(2, 2'b10, 1'b0);
    rep(5, 2'b11, 1'b0);
    rep(3, 2'b10, 1'b0);
    rep(2, 2'b11, 1'b0);
    rep(3, 2'b10, 1'b0);
    rep(1, 2'b11, 1'b0);
    rep(5, 2'b10, 1'b0);
    rep(5, 2'b11, 1'b0);
    rep(5, 2'b01, 1'b0);
    rep(1, 2'b01, 1'b1);
    rep(2, 2'b01, 1'b0);
    rep(5, 2'b00, 1'b0);
    rep(3, 2'b10, 1'b0);
    rep(1, 2'b10, 1'b1);
    rep(3, 2'b10, 1'b0);
    rep(2, 2'b01, 1'b0);
    step(2'b01, 1'b0, 1'b0);
    step(2'b01, 1'b0, 1'b0);
    step(2'b01, 1'b0, 1'b1);
    rep(6, 2'b01, 1'b0);
    cur = 2'b01;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 5) == 0) cur = 2'($urandom);
      iv = ($urandom_range(0, 9) == 0) ? (cur ^ 2'($urandom_range(1, 3))) : cur;
      step(iv, $urandom_range(0, 2) == 0, $urandom_range(0, 149) != 0);
    end
    repeat (2) @(posedge clock);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain pending=%0d want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
